// File: rtl/n1_ir_stash.sv
// N1 instruction register with a LIFO stash, fetch retry handshake and sticky
// overflow/underflow flags; the flow controller drives every command.
module n1_ir_stash #(
    parameter int                    IR_WIDTH    = 16,
    parameter int                    STASH_DEPTH = 4,
    parameter int                    EOW_BIT     = 15,
    parameter logic [IR_WIDTH-1:0]   NOP_INSTR   = 16'h0000,
    parameter logic [IR_WIDTH-1:0]   DROP_INSTR  = 16'h0F10,
    parameter logic [IR_WIDTH-1:0]   ZCALL_INSTR = 16'h4000,
    parameter logic [IR_WIDTH-1:0]   ISR_INSTR   = 16'h0F80,
    localparam int                   CW          = $clog2(STASH_DEPTH + 1)
) (
    input  logic                clk_i,
    input  logic                async_rst_i,
    input  logic [IR_WIDTH-1:0] pbus_dat_i,
    input  logic                pbus_ack_i,
    input  logic                fc2ir_capture_i,
    input  logic                fc2ir_stash_i,
    input  logic                fc2ir_expend_i,
    input  logic                fc2ir_force_eow_i,
    input  logic                fc2ir_force_0call_i,
    input  logic                fc2ir_force_drop_i,
    input  logic                fc2ir_force_nop_i,
    input  logic                fc2ir_force_isr_i,
    input  logic                fc2ir_err_clr_i,
    output logic [IR_WIDTH-1:0] ir_o,
    output logic                ir_valid_o,
    output logic                ir_eow_o,
    output logic                ir2fc_rty_o,
    output logic [CW-1:0]       stash_cnt_o,
    output logic                stash_empty_o,
    output logic                stash_full_o,
    output logic                err_ovf_o,
    output logic                err_unf_o,
    output logic [IR_WIDTH-1:0] prb_ir_stash_o
);

    logic [IR_WIDTH-1:0] r_ir;
    logic [IR_WIDTH-1:0] r_stash [STASH_DEPTH];
    logic [CW-1:0]       r_cnt;
    logic                r_valid;
    logic                r_rty;
    logic                r_errOvf;
    logic                r_errUnf;

    logic                w_force;
    logic                w_expend;
    logic                w_empty;
    logic                w_full;
    logic [IR_WIDTH-1:0] w_top;
    logic [IR_WIDTH-1:0] w_loadVal;
    logic                w_nextValid;
    logic                w_rty;
    logic                w_wrEn;
    logic [CW-1:0]       w_wrIdx;
    logic [CW-1:0]       w_cntNext;
    logic                w_newOvf;
    logic                w_newUnf;

    // A force pre-empts expend entirely, so the pop is only seen when no force is active.
    always_comb begin
        w_force  = fc2ir_force_isr_i | fc2ir_force_0call_i | fc2ir_force_drop_i | fc2ir_force_nop_i;
        w_expend = fc2ir_expend_i & ~w_force;
        w_empty  = (r_cnt == '0);
        w_full   = (r_cnt == CW'(STASH_DEPTH));

        w_top = NOP_INSTR;
        for (int i = 0; i < STASH_DEPTH; i++) begin
            if (r_cnt == CW'(i + 1)) w_top = r_stash[i];
        end

        w_loadVal   = r_ir;
        w_nextValid = r_valid;
        if (fc2ir_force_isr_i) begin
            w_loadVal   = ISR_INSTR;
            w_nextValid = 1'b1;
        end else if (fc2ir_force_0call_i) begin
            w_loadVal   = ZCALL_INSTR;
            w_nextValid = 1'b1;
        end else if (fc2ir_force_drop_i) begin
            w_loadVal   = DROP_INSTR;
            w_nextValid = 1'b1;
        end else if (fc2ir_force_nop_i) begin
            w_loadVal   = NOP_INSTR;
            w_nextValid = 1'b1;
        end else if (w_expend) begin
            w_loadVal   = w_top;
            w_nextValid = 1'b1;
        end else if (fc2ir_capture_i) begin
            if (pbus_ack_i) w_loadVal = pbus_dat_i;
            w_nextValid = pbus_ack_i;
        end
        if (fc2ir_force_eow_i) w_loadVal[EOW_BIT] = 1'b1;

        w_rty = fc2ir_capture_i & ~w_force & ~w_expend & ~pbus_ack_i;

        // Stash and expend together on a non-empty stash overwrite the top in place.
        w_wrEn    = 1'b0;
        w_wrIdx   = r_cnt;
        w_cntNext = r_cnt;
        w_newOvf  = 1'b0;
        w_newUnf  = w_expend & w_empty;
        if (fc2ir_stash_i && w_expend && !w_empty) begin
            w_wrEn  = 1'b1;
            w_wrIdx = r_cnt - CW'(1);
        end else if (fc2ir_stash_i) begin
            if (w_full) begin
                w_newOvf = 1'b1;
            end else begin
                w_wrEn    = 1'b1;
                w_cntNext = r_cnt + CW'(1);
            end
        end else if (w_expend && !w_empty) begin
            w_cntNext = r_cnt - CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge async_rst_i) begin
        if (!async_rst_i) begin
            r_ir     <= NOP_INSTR;
            r_valid  <= 1'b0;
            r_rty    <= 1'b0;
            r_cnt    <= '0;
            r_errOvf <= 1'b0;
            r_errUnf <= 1'b0;
        end else begin
            r_ir     <= w_loadVal;
            r_valid  <= w_nextValid;
            r_rty    <= w_rty;
            r_cnt    <= w_cntNext;
            r_errOvf <= (r_errOvf & ~fc2ir_err_clr_i) | w_newOvf;
            r_errUnf <= (r_errUnf & ~fc2ir_err_clr_i) | w_newUnf;
        end
    end

    // Entry storage needs no reset; the occupancy count alone decides what is visible.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < STASH_DEPTH; i++) begin
            if (w_wrEn && (w_wrIdx == CW'(i))) r_stash[i] <= r_ir;
        end
    end

    assign ir_o           = r_ir;
    assign ir_valid_o     = r_valid;
    assign ir_eow_o       = r_ir[EOW_BIT];
    assign ir2fc_rty_o    = r_rty;
    assign stash_cnt_o    = r_cnt;
    assign stash_empty_o  = w_empty;
    assign stash_full_o   = w_full;
    assign err_ovf_o      = r_errOvf;
    assign err_unf_o      = r_errUnf;
    assign prb_ir_stash_o = w_top;

endmodule

// File: tb/tb_n1_ir_stash.sv
// Directed bench for n1_ir_stash: drives flow-controller commands cycle by cycle
// and compares the outputs against hand-computed values.
module tb_n1_ir_stash;

    localparam logic [8:0] C_CAP   = 9'h001;
    localparam logic [8:0] C_STASH = 9'h002;
    localparam logic [8:0] C_EXP   = 9'h004;
    localparam logic [8:0] C_EOW   = 9'h008;
    localparam logic [8:0] C_NOP   = 9'h010;
    localparam logic [8:0] C_DROP  = 9'h020;
    localparam logic [8:0] C_ZCALL = 9'h040;
    localparam logic [8:0] C_ISR   = 9'h080;
    localparam logic [8:0] C_CLR   = 9'h100;

    logic        clk_i = 1'b0;
    logic        async_rst_i = 1'b0;
    logic [15:0] pbus_dat_i = '0;
    logic        pbus_ack_i = 1'b0;
    logic        fc2ir_capture_i = 1'b0;
    logic        fc2ir_stash_i = 1'b0;
    logic        fc2ir_expend_i = 1'b0;
    logic        fc2ir_force_eow_i = 1'b0;
    logic        fc2ir_force_0call_i = 1'b0;
    logic        fc2ir_force_drop_i = 1'b0;
    logic        fc2ir_force_nop_i = 1'b0;
    logic        fc2ir_force_isr_i = 1'b0;
    logic        fc2ir_err_clr_i = 1'b0;
    logic [15:0] ir_o;
    logic        ir_valid_o;
    logic        ir_eow_o;
    logic        ir2fc_rty_o;
    logic [2:0]  stash_cnt_o;
    logic        stash_empty_o;
    logic        stash_full_o;
    logic        err_ovf_o;
    logic        err_unf_o;
    logic [15:0] prb_ir_stash_o;

    int checkCount = 0;
    int passCount  = 0;

    n1_ir_stash dut (
        .clk_i               (clk_i),
        .async_rst_i         (async_rst_i),
        .pbus_dat_i          (pbus_dat_i),
        .pbus_ack_i          (pbus_ack_i),
        .fc2ir_capture_i     (fc2ir_capture_i),
        .fc2ir_stash_i       (fc2ir_stash_i),
        .fc2ir_expend_i      (fc2ir_expend_i),
        .fc2ir_force_eow_i   (fc2ir_force_eow_i),
        .fc2ir_force_0call_i (fc2ir_force_0call_i),
        .fc2ir_force_drop_i  (fc2ir_force_drop_i),
        .fc2ir_force_nop_i   (fc2ir_force_nop_i),
        .fc2ir_force_isr_i   (fc2ir_force_isr_i),
        .fc2ir_err_clr_i     (fc2ir_err_clr_i),
        .ir_o                (ir_o),
        .ir_valid_o          (ir_valid_o),
        .ir_eow_o            (ir_eow_o),
        .ir2fc_rty_o         (ir2fc_rty_o),
        .stash_cnt_o         (stash_cnt_o),
        .stash_empty_o       (stash_empty_o),
        .stash_full_o        (stash_full_o),
        .err_ovf_o           (err_ovf_o),
        .err_unf_o           (err_unf_o),
        .prb_ir_stash_o      (prb_ir_stash_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        if (obs === exp) passCount++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    // Drives one cycle of commands, lets the edge take them, then idles the command lines.
    task automatic applyStimulus(input logic [8:0] cmd, input logic ack, input logic [15:0] dat);
        fc2ir_capture_i     = cmd[0];
        fc2ir_stash_i       = cmd[1];
        fc2ir_expend_i      = cmd[2];
        fc2ir_force_eow_i   = cmd[3];
        fc2ir_force_nop_i   = cmd[4];
        fc2ir_force_drop_i  = cmd[5];
        fc2ir_force_0call_i = cmd[6];
        fc2ir_force_isr_i   = cmd[7];
        fc2ir_err_clr_i     = cmd[8];
        pbus_ack_i          = ack;
        pbus_dat_i          = dat;
        @(posedge clk_i);
        #1;
        fc2ir_capture_i     = 1'b0;
        fc2ir_stash_i       = 1'b0;
        fc2ir_expend_i      = 1'b0;
        fc2ir_force_eow_i   = 1'b0;
        fc2ir_force_nop_i   = 1'b0;
        fc2ir_force_drop_i  = 1'b0;
        fc2ir_force_0call_i = 1'b0;
        fc2ir_force_isr_i   = 1'b0;
        fc2ir_err_clr_i     = 1'b0;
        pbus_ack_i          = 1'b0;
    endtask

    initial begin
        logic [15:0] popExp [4];
        popExp[0] = 16'h0004;
        popExp[1] = 16'h0003;
        popExp[2] = 16'h0002;
        popExp[3] = 16'h0001;

        repeat (2) @(negedge clk_i);
        async_rst_i = 1'b1;
        @(negedge clk_i);
        checkOutput("rst_ir", ir_o, 16'h0000);
        checkOutput("rst_valid", ir_valid_o, 1'b0);
        checkOutput("rst_cnt", stash_cnt_o, 3'd0);
        checkOutput("rst_empty", stash_empty_o, 1'b1);
        checkOutput("rst_ovf", err_ovf_o, 1'b0);
        checkOutput("rst_unf", err_unf_o, 1'b0);
        checkOutput("rst_rty", ir2fc_rty_o, 1'b0);

        applyStimulus(C_CAP, 1'b1, 16'h8123);
        checkOutput("cap_ir", ir_o, 16'h8123);
        checkOutput("cap_eow", ir_eow_o, 1'b1);
        checkOutput("cap_valid", ir_valid_o, 1'b1);
        checkOutput("cap_rty", ir2fc_rty_o, 1'b0);
        applyStimulus(C_CAP, 1'b0, 16'hFFFF);
        checkOutput("nack_ir", ir_o, 16'h8123);
        checkOutput("nack_valid", ir_valid_o, 1'b0);
        checkOutput("nack_rty", ir2fc_rty_o, 1'b1);
        applyStimulus('0, 1'b0, 16'h0000);
        checkOutput("rty_drop", ir2fc_rty_o, 1'b0);

        applyStimulus(C_CAP, 1'b1, 16'h0001);
        for (int i = 2; i <= 5; i++) applyStimulus(C_STASH | C_CAP, 1'b1, 16'(i));
        checkOutput("fill_ir", ir_o, 16'h0005);
        checkOutput("fill_cnt", stash_cnt_o, 3'd4);
        checkOutput("fill_full", stash_full_o, 1'b1);
        checkOutput("fill_ovf", err_ovf_o, 1'b0);
        checkOutput("fill_top", prb_ir_stash_o, 16'h0004);
        applyStimulus(C_STASH, 1'b0, 16'h0000);
        checkOutput("ovf_flag", err_ovf_o, 1'b1);
        checkOutput("ovf_cnt", stash_cnt_o, 3'd4);
        checkOutput("ovf_top", prb_ir_stash_o, 16'h0004);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(C_EXP, 1'b0, 16'h0000);
            checkOutput($sformatf("pop%0d_ir", i), ir_o, popExp[i]);
            checkOutput($sformatf("pop%0d_cnt", i), stash_cnt_o, 32'(3 - i));
        end
        checkOutput("pop_unf0", err_unf_o, 1'b0);
        applyStimulus(C_EXP, 1'b0, 16'h0000);
        checkOutput("unf_ir", ir_o, 16'h0000);
        checkOutput("unf_valid", ir_valid_o, 1'b1);
        checkOutput("unf_flag", err_unf_o, 1'b1);
        checkOutput("unf_prb", prb_ir_stash_o, 16'h0000);
        applyStimulus(C_CLR | C_EXP, 1'b0, 16'h0000);
        checkOutput("clr_vs_unf", err_unf_o, 1'b1);
        checkOutput("clr_ovf", err_ovf_o, 1'b0);

        applyStimulus(C_CAP, 1'b1, 16'h0022);
        applyStimulus(C_STASH | C_CAP, 1'b1, 16'h0011);
        applyStimulus(C_STASH | C_EXP, 1'b0, 16'h0000);
        checkOutput("swap_ir", ir_o, 16'h0022);
        checkOutput("swap_top", prb_ir_stash_o, 16'h0011);
        checkOutput("swap_cnt", stash_cnt_o, 3'd1);

        applyStimulus(C_ISR | C_NOP | C_EXP | C_CAP, 1'b1, 16'h1234);
        checkOutput("isr_ir", ir_o, 16'h0F80);
        checkOutput("isr_cnt", stash_cnt_o, 3'd1);
        checkOutput("isr_top", prb_ir_stash_o, 16'h0011);
        applyStimulus(C_NOP | C_EOW, 1'b0, 16'h0000);
        checkOutput("nop_eow", ir_o, 16'h8000);
        applyStimulus(C_DROP | C_CAP, 1'b1, 16'h1234);
        checkOutput("drop_ir", ir_o, 16'h0F10);
        applyStimulus(C_ZCALL | C_DROP, 1'b0, 16'h0000);
        checkOutput("zcall_ir", ir_o, 16'h4000);
        applyStimulus(C_EOW, 1'b0, 16'h0000);
        checkOutput("eow_hold", ir_o, 16'hC000);
        applyStimulus(C_STASH | C_DROP, 1'b0, 16'h0000);
        checkOutput("push_force_ir", ir_o, 16'h0F10);
        checkOutput("push_force_top", prb_ir_stash_o, 16'hC000);
        applyStimulus(C_STASH, 1'b0, 16'h0000);
        checkOutput("pre_rst_cnt", stash_cnt_o, 3'd3);
        checkOutput("sticky_unf", err_unf_o, 1'b1);

        #2;
        async_rst_i = 1'b0;
        #1;
        checkOutput("arst_ir", ir_o, 16'h0000);
        checkOutput("arst_cnt", stash_cnt_o, 3'd0);
        checkOutput("arst_valid", ir_valid_o, 1'b0);
        checkOutput("arst_unf", err_unf_o, 1'b0);
        checkOutput("arst_prb", prb_ir_stash_o, 16'h0000);
        repeat (2) @(negedge clk_i);
        async_rst_i = 1'b1;
        @(negedge clk_i);

        applyStimulus(C_CAP, 1'b1, 16'h0055);
        applyStimulus(C_STASH | C_EXP, 1'b0, 16'h0000);
        checkOutput("eswap_ir", ir_o, 16'h0000);
        checkOutput("eswap_cnt", stash_cnt_o, 3'd1);
        checkOutput("eswap_top", prb_ir_stash_o, 16'h0055);
        checkOutput("eswap_unf", err_unf_o, 1'b1);
        applyStimulus(C_CLR, 1'b0, 16'h0000);
        checkOutput("final_clr", err_unf_o, 1'b0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/n1_ir_stash.md
Name: n1_ir_stash

Overview:
- Parametrised successor to the N1 instruction register.
- Holds the current instruction word fetched from the program bus.
- Replaces the single stash register with a LIFO stash of configurable depth and width.
- Adds a fetch-acknowledge handshake with retry, and sticky overflow/underflow error flags.
- Sits between the program bus read-data path and instruction decode; the flow controller (FC) drives all commands.

Parameters:
- IR_WIDTH, 16, instruction word width in bits (minimum 8).
- STASH_DEPTH, 4, number of stash entries (minimum 1).
- EOW_BIT, 15, bit index of the end-of-word flag inside the instruction word.
- NOP_INSTR, 16'h0000, encoding loaded by force_nop, by an empty-stash expend, and at reset.
- DROP_INSTR, 16'h0F10, encoding loaded by force_drop.
- ZCALL_INSTR, 16'h4000, encoding loaded by force_0call (call to address 0).
- ISR_INSTR, 16'h0F80, encoding loaded by force_isr.

Ports:
- clk_i  in  1  module clock.
- async_rst_i  in  1  asynchronous reset, active-low.
- pbus_dat_i  in  IR_WIDTH  program bus read data.
- pbus_ack_i  in  1  read data valid this cycle.
- fc2ir_capture_i  in  1  load IR from pbus_dat_i.
- fc2ir_stash_i  in  1  push current IR onto stash.
- fc2ir_expend_i  in  1  pop stash top into IR.
- fc2ir_force_eow_i  in  1  set EOW_BIT in the value being loaded.
- fc2ir_force_0call_i  in  1  load ZCALL_INSTR.
- fc2ir_force_drop_i  in  1  load DROP_INSTR.
- fc2ir_force_nop_i  in  1  load NOP_INSTR.
- fc2ir_force_isr_i  in  1  load ISR_INSTR.
- fc2ir_err_clr_i  in  1  clear sticky error flags.
- ir_o  out  IR_WIDTH  current instruction.
- ir_valid_o  out  1  ir_o holds a usable instruction.
- ir_eow_o  out  1  ir_o[EOW_BIT].
- ir2fc_rty_o  out  1  capture attempted without ack; FC must retry.
- stash_cnt_o  out  $clog2(STASH_DEPTH+1)  occupied stash entries.
- stash_empty_o  out  1  stash_cnt_o==0.
- stash_full_o  out  1  stash_cnt_o==STASH_DEPTH.
- err_ovf_o  out  1  sticky: push attempted while full.
- err_unf_o  out  1  sticky: expend attempted while empty.
- prb_ir_stash_o  out  IR_WIDTH  stash top entry (NOP_INSTR when empty).

Behaviour:
- Reset (async_rst_i low, asynchronous assert, synchronous release):
  - ir_o=NOP_INSTR, ir_valid_o=0, ir2fc_rty_o=0.
  - Stash emptied, stash_cnt_o=0, both error flags=0.
  - Reset mid-operation discards all stash contents and any pending command.
- All state is registered; every command takes effect on the next rising clk_i edge (1-cycle latency). The outputs ir_eow_o, stash_empty_o, stash_full_o and prb_ir_stash_o decode combinationally from registers.
- IR load source, priority from highest to lowest:
  - force_isr
  - force_0call
  - force_drop
  - force_nop
  - expend
  - capture
  - none: hold
- force_eow is orthogonal: it ORs 1 into EOW_BIT of whichever value is loaded. With no load selected, it sets EOW_BIT of the held IR.
- Forced loads and expend always set ir_valid_o=1.
- Capture:
  - With pbus_ack_i=1: IR<=pbus_dat_i, ir_valid_o<=1, rty<=0.
  - With pbus_ack_i=0: IR held, ir_valid_o<=0, rty<=1 for one cycle.
  - ir2fc_rty_o<=0 on any cycle without a failed capture.
- Stash push (fc2ir_stash_i): pushes the pre-update IR value.
- Expend (fc2ir_expend_i) is honoured as the IR source only if no force is active. If a force pre-empts it, the pop is suppressed and the stash is unchanged.
- Stash and expend asserted together (expend honoured): swap. IR<=top, top<=old IR, count unchanged. On an empty stash this is a plain push, and IR<=NOP_INSTR with err_unf set.
- Push while full: push dropped, contents unchanged, err_ovf_o<=1. The IR load still happens.
- Expend while empty: IR<=NOP_INSTR, ir_valid_o<=1, err_unf_o<=1.
- Stash push combined with a force or capture load: push the old IR first, then load the new value. Both happen in the same cycle.
- Error flags stay set until fc2ir_err_clr_i. If clear and a new error coincide, the flag stays set.
- The stash is implemented as a register array plus a pointer. Entry storage has no reset dependency beyond the pointer; prb_ir_stash_o masks to NOP_INSTR when empty.

Test Plan:
- Reset release, no commands → ir_o=16'h0000, ir_valid_o=0, stash_cnt_o=0, both error flags 0.
- capture with ack=1 and pbus_dat_i=16'h8123 → next cycle ir_o=16'h8123, ir_eow_o=1, ir_valid_o=1. Then capture with ack=0 → ir_o held, ir_valid_o=0, ir2fc_rty_o=1 for exactly one cycle.
- Load 16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005, stashing each before the next load → 4 entries stored, err_ovf_o=1 on the 5th push. Then expend ×4 → ir_o=16'h0004, 16'h0003, 16'h0002, 16'h0001. A 5th expend → ir_o=16'h0000, err_unf_o=1.
- IR=16'h0011, stash top=16'h0022, stash and expend in the same cycle → ir_o=16'h0022, top=16'h0011, stash_cnt_o unchanged.
- force_isr, force_nop, expend and capture all asserted together → ir_o=16'h0F80, stash not popped. force_nop with force_eow → ir_o=16'h8000.
- Assert async_rst_i low mid-sequence with stash_cnt_o=3 → immediately ir_o=16'h0000, stash_cnt_o=0, flags cleared, without waiting for a clock edge.
